vec_unit_vl: RTL and testbench
==============================

// Module: vec_unit_vl
// PURPOSE
// Self-contained vector unit: register file (VRF) plus lanes_p parallel element ALUs.
// Runtime vector length (vl_i), tail masking, optional unsigned saturation, illegal-op flagging.
// Sits behind the host command port; strip-mines each command over ceil(vl/lanes_p) beats.
// PARAMETERS
// els_p    8   number of vectors in the VRF
// vlen_p   16  max elements per vector; must be a multiple of lanes_p
// vdw_p    8   bits per element (unsigned)
// lanes_p  4   elements processed per beat
// Derived widths: AW = clog2(els_p); VLW = clog2(vlen_p+1).
// PORTS
// clk_i      in   1            clock, rising edge
// reset_n_i  in   1            asynchronous reset, active-low
// op_i       in   4            opcode (see BEHAVIOUR)
// addrA_i    in   AW           source vector A
// addrB_i    in   AW           source vector B
// addrD_i    in   AW           destination vector
// vl_i       in   VLW          active element count
// scalar_i   in   vdw_p        scalar operand for v&s ops
// sat_i      in   1            1 = saturate arithmetic results
// w_data_i   in   vlen_p*vdw_p write-op data; element k at bits [k*vdw_p +: vdw_p]
// v_i        in   1            command valid
// ready_o    out  1            command accepted when v_i & ready_o
// r_data_o   out  vlen_p*vdw_p read-op result, same packing as w_data_i
// v_o        out  1            r_data_o valid (read ops only)
// yumi_i     in   1            consumer takes r_data_o; legal only while v_o
// done_o     out  1            one-cycle pulse: non-read command complete
// err_o      out  1            one-cycle pulse: illegal opcode rejected
// BEHAVIOUR
// - Reset (async, reset_n_i=0): state IDLE; ready_o=1; v_o, done_o, err_o=0; r_data_o=0; VRF cleared to 0.
// - Opcodes: 0000 D=A+B; 0001 D=A-B; 0010 D=A*B (low vdw_p bits); 0100 D=A+s; 0101 D=A-s;
//   0110 D=A*s; 1000 read A to r_data_o; 1001 write w_data_i to D. All other codes illegal.
// - States: IDLE, EXEC, DONE, RESP.
//   IDLE: ready_o=1. On v_i with legal op: latch op/addrs/vl/scalar/sat/w_data; go EXEC.
//     On v_i with illegal op: err_o=1 next cycle; stay IDLE; no VRF change.
//   EXEC: beat counter b = 0..B-1, where B = ceil(vl/lanes_p). Each cycle, lane l handles element
//     e = b*lanes_p+l. VRF is read combinationally; the write lands at the cycle's edge.
//     Elements with e >= vl are masked: no write, read result 0. After beat B-1: read goes RESP, else DONE.
//   DONE: done_o=1 for exactly one cycle; next state IDLE.
//   RESP: v_o=1 and r_data_o held stable until yumi_i; then IDLE. r_data_o is cleared at the next accept.
// - vl_i > vlen_p is clamped to vlen_p. vl_i = 0 gives B = 0: EXEC is skipped.
//   Accept -> DONE (or RESP, with r_data_o all zero) on the next cycle; the VRF is untouched.
// - Latency: accept at edge T; beats occupy cycles T+1..T+B; done_o/v_o rise at T+B+1.
// - Aliasing: addrD equal to addrA and/or addrB is legal. Each element is read and written in the same beat.
//   Result is identical to the non-aliased case.
// - Arithmetic (unsigned vdw_p), sat_i=0: wrap modulo 2^vdw_p.
//   sat_i=1: add/mul clamp to 2^vdw_p-1; sub clamps to 0. sat_i is ignored for read/write.
// - Write op stores element e of latched w_data_i for e < vl; elements e >= vl of D are unchanged.
// - Command inputs are sampled only at accept; later changes have no effect on the running command.
// - yumi_i outside RESP is ignored. v_i outside IDLE is ignored (not queued).
// - Reset asserted mid-command aborts it. Partial VRF writes are discarded by the VRF clear.
// TESTING
// 1 write D=1, vl=16, elem k=k -> done_o at T+5; then read A=1, vl=16 -> v_o at T+5, r_data_o elem k=k.
// 2 add A=1,B=1,D=2, vl=6 -> elems 0..5 = 2k, elems 6..15 unchanged (0); done_o at T+3 (B=2).
// 3 vdw_p=8: A=200,B=100 add sat=0 -> 44; sat=1 -> 255; sub 100-200 sat=1 -> 0, sat=0 -> 156.
// 4 mul-vs A=1 (elem=k), s=3, D=1 aliased, vl=16 -> elem k = 3k; vl=20 behaves as vl=16.
// 5 op=0111 -> err_o pulse, ready_o stays 1, VRF unchanged; vl=0 add -> done_o at T+1, no writes.
// 6 read with yumi_i held 0 for 10 cycles -> v_o and r_data_o stable; v_i ignored until after yumi_i.
//   Async reset mid-EXEC -> outputs at reset values immediately, VRF reads 0.

Source files
------------

// File: rtl/vec_unit_vl.sv
// Vector unit: VRF plus lanes_p element ALUs, strip-mining each command over ceil(vl/lanes_p) beats.
// Latency B+1 cycles from accept to done_o/v_o; a read result is held until yumi_i and new commands wait.
module vec_unit_vl #(
  parameter int els_p   = 8,
  parameter int vlen_p  = 16,
  parameter int vdw_p   = 8,
  parameter int lanes_p = 4,
  localparam int AW  = $clog2(els_p),
  localparam int VLW = $clog2(vlen_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [3:0]              op_i,
  input  logic [AW-1:0]           addrA_i,
  input  logic [AW-1:0]           addrB_i,
  input  logic [AW-1:0]           addrD_i,
  input  logic [VLW-1:0]          vl_i,
  input  logic [vdw_p-1:0]        scalar_i,
  input  logic                    sat_i,
  input  logic [vlen_p*vdw_p-1:0] w_data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [vlen_p*vdw_p-1:0] r_data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int EW = $clog2(vlen_p);
  localparam int BW = $clog2(vlen_p / lanes_p + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, RESP} state_t;

  state_t state_q, state_d;

  logic [vdw_p-1:0]        vrf [els_p][vlen_p];
  logic [3:0]              op_q;
  logic [AW-1:0]           a_q, b_q, d_q;
  logic [VLW-1:0]          vl_q;
  logic [vdw_p-1:0]        s_q;
  logic                    sat_q;
  logic [vlen_p*vdw_p-1:0] wd_q;
  logic [vlen_p*vdw_p-1:0] r_data_q;
  logic [BW-1:0]           beat_q;
  logic                    err_q;

  logic [VLW-1:0]   vl_c;
  logic [VLW-1:0]   next_base;
  logic             last_beat;
  logic             is_read, is_write, accept_ok;
  logic [VLW-1:0]   lane_e   [lanes_p];
  logic [EW-1:0]    lane_idx [lanes_p];
  logic             lane_en  [lanes_p];
  logic [vdw_p-1:0] lane_res [lanes_p];

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // fn: 00 add, 01 sub, 10 mul; saturation clamps at the unsigned range limits
  function automatic logic [vdw_p-1:0] alu(input logic [1:0] fn, input logic sat,
                                           input logic [vdw_p-1:0] a, input logic [vdw_p-1:0] b);
    logic [vdw_p:0]     sum;
    logic [2*vdw_p-1:0] prod;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{vdw_p{1'b0}}, a} * {{vdw_p{1'b0}}, b};
    case (fn)
      2'b00:   return (sat && sum[vdw_p]) ? '1 : sum[vdw_p-1:0];
      2'b01:   return (sat && (a < b)) ? '0 : a - b;
      default: return (sat && (|prod[2*vdw_p-1:vdw_p])) ? '1 : prod[vdw_p-1:0];
    endcase
  endfunction

  assign vl_c      = (vl_i > VLW'(vlen_p)) ? VLW'(vlen_p) : vl_i;
  assign is_read   = (op_q == 4'h8);
  assign is_write  = (op_q == 4'h9);
  assign accept_ok = (state_q == IDLE) && v_i && legal_op(op_i);
  assign next_base = (VLW'(beat_q) + VLW'(1)) * VLW'(lanes_p);
  assign last_beat = (next_base >= vl_q);

  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      lane_e[l]   = VLW'(beat_q) * VLW'(lanes_p) + VLW'(l);
      lane_idx[l] = lane_e[l][EW-1:0];
      lane_en[l]  = (state_q == EXEC) && (lane_e[l] < vl_q);
      lane_res[l] = is_write ? wd_q[lane_idx[l]*vdw_p +: vdw_p]
                             : alu(op_q[1:0], sat_q, vrf[a_q][lane_idx[l]],
                                   op_q[2] ? s_q : vrf[b_q][lane_idx[l]]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_ok) begin
        if (vl_c == '0) state_d = (op_i == 4'h8) ? RESP : DONE;
        else            state_d = EXEC;
      end
      EXEC: if (last_beat) state_d = is_read ? RESP : DONE;
      DONE: state_d = IDLE;
      RESP: if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    v_o      = (state_q == RESP);
    done_o   = (state_q == DONE);
    err_o    = err_q;
    r_data_o = r_data_q;
  end

  // Aliased D/A/B is safe: every lane reads its element combinationally before the edge writes it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int v = 0; v < els_p; v++)
        for (int e = 0; e < vlen_p; e++)
          vrf[v][e] <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      vl_q     <= '0;
      s_q      <= '0;
      sat_q    <= 1'b0;
      wd_q     <= '0;
      r_data_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE && v_i) begin
        r_data_q <= '0;
        if (legal_op(op_i)) begin
          op_q   <= op_i;
          a_q    <= addrA_i;
          b_q    <= addrB_i;
          d_q    <= addrD_i;
          vl_q   <= vl_c;
          s_q    <= scalar_i;
          sat_q  <= sat_i;
          wd_q   <= w_data_i;
          beat_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        beat_q <= beat_q + 1'b1;
        for (int l = 0; l < lanes_p; l++) begin
          if (lane_en[l]) begin
            if (is_read) r_data_q[lane_idx[l]*vdw_p +: vdw_p] <= vrf[a_q][lane_idx[l]];
            else         vrf[d_q][lane_idx[l]] <= lane_res[l];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_unit_vl.sv
// Self-checking bench for vec_unit_vl: constant tables, hand sequences and a random run against a reference model.
module tb_vec_unit_vl;
  localparam int ELS = 8, VLEN = 16, VDW = 8, LANES = 4;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [3:0]   op_i;
  logic [2:0]   addrA_i, addrB_i, addrD_i;
  logic [4:0]   vl_i;
  logic [7:0]   scalar_i;
  logic         sat_i;
  logic [127:0] w_data_i;
  logic         v_i;
  logic         ready_o;
  logic [127:0] r_data_o;
  logic         v_o;
  logic         yumi_i;
  logic         done_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  vec_unit_vl #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .op_i(op_i), .addrA_i(addrA_i), .addrB_i(addrB_i),
    .addrD_i(addrD_i), .vl_i(vl_i), .scalar_i(scalar_i), .sat_i(sat_i), .w_data_i(w_data_i),
    .v_i(v_i), .ready_o(ready_o), .r_data_o(r_data_o), .v_o(v_o), .yumi_i(yumi_i),
    .done_o(done_o), .err_o(err_o)
  );

  int           n_tests = 0;
  int           n_fail = 0;
  int           ref_vrf [ELS][VLEN];
  logic [127:0] last_rd;

  typedef struct {
    logic [3:0] op;
    logic       sat;
    int         a;
    int         b;
    int         s;
    int         exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_alu(input logic [3:0] op, input logic sat, input int a, input int b);
    int r;
    case (op[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      default: r = a * b;
    endcase
    if (sat) begin
      if (r > 255) r = 255;
      if (r < 0) r = 0;
    end else begin
      r = ((r % 256) + 256) % 256;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_read(input int a, input int vlc);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < vlc; e++) r[e*8 +: 8] = 8'(ref_vrf[a][e]);
    return r;
  endfunction

  // Results are computed from the old vector contents first, so aliasing cannot leak into later elements
  task automatic ref_apply(input logic [3:0] op, input int a, input int b, input int d, input int vlc,
                           input int s, input logic sat, input logic [127:0] wd);
    int tmp [VLEN];
    for (int e = 0; e < VLEN; e++) tmp[e] = ref_vrf[d][e];
    for (int e = 0; e < vlc; e++) begin
      if (op == 4'h9) tmp[e] = int'(wd[e*8 +: 8]);
      else tmp[e] = ref_alu(op, sat, ref_vrf[a][e], op[2] ? s : ref_vrf[b][e]);
    end
    for (int e = 0; e < VLEN; e++) ref_vrf[d][e] = tmp[e];
  endtask

  task automatic ref_clear();
    for (int v = 0; v < ELS; v++)
      for (int e = 0; e < VLEN; e++)
        ref_vrf[v][e] = 0;
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle
  task automatic run_cmd(input logic [3:0] op, input int a, input int b, input int d, input int vl,
                         input int s, input logic sat, input logic [127:0] wd);
    int n, vlc, exp_b;
    logic [127:0] exp_rd;
    check("ready_before_cmd", 128'(ready_o), 128'(1));
    op_i = op; addrA_i = 3'(a); addrB_i = 3'(b); addrD_i = 3'(d);
    vl_i = 5'(vl); scalar_i = 8'(s); sat_i = sat; w_data_i = wd; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    op_i = 4'($urandom); addrA_i = 3'($urandom); addrB_i = 3'($urandom); addrD_i = 3'($urandom);
    vl_i = 5'($urandom); scalar_i = 8'($urandom); sat_i = 1'($urandom);
    w_data_i = {$urandom, $urandom, $urandom, $urandom};
    if (!is_legal(op)) begin
      check("err_pulse", 128'(err_o), 128'(1));
      check("err_ready", 128'(ready_o), 128'(1));
      @(posedge clk_i); #1;
      check("err_one_cycle", 128'(err_o), 128'(0));
      return;
    end
    vlc = (vl > VLEN) ? VLEN : vl;
    exp_b = (vlc + LANES - 1) / LANES;
    n = 0;
    while (!(done_o || v_o) && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    check($sformatf("latency_op%0h_vl%0d", op, vl), 128'(n), 128'(exp_b));
    if (op == 4'h8) begin
      exp_rd = ref_read(a, vlc);
      check("read_v_o", 128'(v_o), 128'(1));
      check($sformatf("read_data_v%0d_vl%0d", a, vl), r_data_o, exp_rd);
      last_rd = r_data_o;
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      check("v_o_after_yumi", 128'(v_o), 128'(0));
    end else begin
      check("done_pulse", 128'(done_o), 128'(1));
      check("done_no_err", 128'(err_o), 128'(0));
      ref_apply(op, a, b, d, vlc, s, sat, wd);
      @(posedge clk_i); #1;
      check("done_one_cycle", 128'(done_o), 128'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wd, exp_v;
    logic [3:0]   legal_ops [8];
    logic [3:0]   op;

    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    tbl[0]  = '{4'h0, 1'b0, 3, 4, 0,   44};
    tbl[1]  = '{4'h0, 1'b1, 3, 4, 0,   255};
    tbl[2]  = '{4'h1, 1'b1, 4, 3, 0,   0};
    tbl[3]  = '{4'h1, 1'b0, 4, 3, 0,   156};
    tbl[4]  = '{4'h2, 1'b0, 3, 4, 0,   32};
    tbl[5]  = '{4'h2, 1'b1, 3, 4, 0,   255};
    tbl[6]  = '{4'h1, 1'b0, 3, 4, 0,   100};
    tbl[7]  = '{4'h4, 1'b0, 3, 0, 60,  4};
    tbl[8]  = '{4'h4, 1'b1, 3, 0, 60,  255};
    tbl[9]  = '{4'h5, 1'b1, 4, 0, 150, 0};
    tbl[10] = '{4'h6, 1'b0, 4, 0, 2,   200};
    tbl[11] = '{4'h6, 1'b1, 4, 0, 3,   255};

    reset_n_i = 1'b0; op_i = '0; addrA_i = '0; addrB_i = '0; addrD_i = '0; vl_i = '0;
    scalar_i = '0; sat_i = 1'b0; w_data_i = '0; v_i = 1'b0; yumi_i = 1'b0;
    ref_clear();
    #12;
    check("rst_ready", 128'(ready_o), 128'(1));
    check("rst_v_o", 128'(v_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_err", 128'(err_o), 128'(0));
    check("rst_rdata", r_data_o, 128'(0));
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // write ramp, read it back
    for (int k = 0; k < VLEN; k++) wd[k*8 +: 8] = 8'(k);
    run_cmd(4'h9, 0, 0, 1, 16, 0, 1'b0, wd);
    run_cmd(4'h8, 1, 0, 0, 16, 0, 1'b0, '0);
    for (int k = 0; k < VLEN; k++) exp_v[k*8 +: 8] = 8'(k);
    check("ramp_readback", last_rd, exp_v);

    // partial-length add leaves the tail untouched
    run_cmd(4'h0, 1, 1, 2, 6, 0, 1'b0, '0);
    run_cmd(4'h8, 2, 0, 0, 16, 0, 1'b0, '0);
    for (int k = 0; k < VLEN; k++) exp_v[k*8 +: 8] = (k < 6) ? 8'(2 * k) : 8'(0);
    check("add_vl6_tail", last_rd, exp_v);

    // saturation / wrap table
    run_cmd(4'h9, 0, 0, 3, 16, 0, 1'b0, {16{8'd200}});
    run_cmd(4'h9, 0, 0, 4, 16, 0, 1'b0, {16{8'd100}});
    for (int i = 0; i < 12; i++) begin
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, 5, 16, tbl[i].s, tbl[i].sat, '0);
      run_cmd(4'h8, 5, 0, 0, 16, 0, 1'b0, '0);
      check($sformatf("table_%0d", i), last_rd, {16{8'(tbl[i].exp)}});
    end

    // aliased scalar multiply, then over-long vl
    run_cmd(4'h6, 1, 0, 1, 16, 3, 1'b0, '0);
    run_cmd(4'h8, 1, 0, 0, 16, 0, 1'b0, '0);
    for (int k = 0; k < VLEN; k++) exp_v[k*8 +: 8] = 8'(3 * k);
    check("mul_vs_alias", last_rd, exp_v);
    run_cmd(4'h6, 1, 0, 6, 20, 2, 1'b0, '0);
    run_cmd(4'h8, 6, 0, 0, 20, 0, 1'b0, '0);

    // illegal opcode and zero-length command
    run_cmd(4'h7, 1, 1, 1, 16, 0, 1'b0, '0);
    run_cmd(4'h8, 1, 0, 0, 16, 0, 1'b0, '0);
    run_cmd(4'h0, 1, 1, 1, 0, 0, 1'b0, '0);
    run_cmd(4'h8, 1, 0, 0, 16, 0, 1'b0, '0);
    run_cmd(4'h8, 1, 0, 0, 0, 0, 1'b0, '0);
    check("read_vl0_zero", last_rd, 128'(0));

    // held response: output stable, new commands ignored
    op_i = 4'h8; addrA_i = 3'd2; vl_i = 5'd16; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    begin
      int n;
      n = 0;
      while (!v_o && n < 40) begin
        @(posedge clk_i); #1;
        n++;
      end
      check("held_latency", 128'(n), 128'(4));
    end
    for (int c = 0; c < 10; c++) begin
      op_i = 4'h9; addrD_i = 3'd2; vl_i = 5'd16; w_data_i = {$urandom, $urandom, $urandom, $urandom};
      v_i = 1'b1;
      check($sformatf("held_v_o_%0d", c), 128'(v_o), 128'(1));
      check($sformatf("held_rdata_%0d", c), r_data_o, ref_read(2, 16));
      @(posedge clk_i); #1;
    end
    v_i = 1'b0; yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check("held_release", 128'(v_o), 128'(0));
    run_cmd(4'h8, 2, 0, 0, 16, 0, 1'b0, '0);

    // randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
      run_cmd(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 20), $urandom_range(0, 255), 1'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
    end

    // reset in the middle of a write
    op_i = 4'h9; addrD_i = 3'd7; vl_i = 5'd16; w_data_i = {16{8'hA5}}; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    check("midrst_ready", 128'(ready_o), 128'(1));
    check("midrst_v_o", 128'(v_o), 128'(0));
    check("midrst_done", 128'(done_o), 128'(0));
    check("midrst_err", 128'(err_o), 128'(0));
    check("midrst_rdata", r_data_o, 128'(0));
    ref_clear();
    #2;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    run_cmd(4'h8, 7, 0, 0, 16, 0, 1'b0, '0);
    run_cmd(4'h8, 1, 0, 0, 16, 0, 1'b0, '0);
    check("midrst_vrf_clear", last_rd, 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
